spi_flash_cmd_parser: RTL and testbench
=======================================

SPI_FLASH_CMD_PARSER -- requirements
Module: spi_flash_cmd_parser

Interface
REQ-001 Parameter ADDR_BITS, default 24, sets the flash address width; the address is always carried as 3 bytes, MSB first.
REQ-002 Parameter SYNC_STAGES, default 2, sets the synchronizer depth for the spi_clk-domain inputs (minimum 2).
REQ-003 Ports `clk` (in, 1) and `reset` (in, 1): `clk` is the system clock; `reset` is synchronous and active-high.
REQ-004 Port `spi_cs` (in, 1): raw chip select, asynchronous to `clk`, high means deselected.
REQ-005 Port `spi_rx_strobe` (in, 1): toggles once per received byte in the spi_clk domain.
REQ-006 Port `spi_rx_cmd` (in, 1): toggles once per CS assertion, on the first byte.
REQ-007 Port `spi_rx_data` (in, 8): last received byte, stable for at least 7 spi_clk periods after each `spi_rx_strobe` toggle.
REQ-008 Ports `cmd_strobe` (out, 1) and `cmd` (out, 8): `cmd_strobe` is a 1-cycle pulse when a new opcode is decoded; `cmd` holds that opcode.
REQ-009 Ports `rd_req` (out, 1) and `rd_addr` (out, ADDR_BITS): `rd_req` is a 1-cycle read request; `rd_addr` holds the byte address.
REQ-010 Ports `wr_strobe` (out, 1), `wr_addr` (out, ADDR_BITS) and `wr_data` (out, 8): `wr_strobe` is a 1-cycle program-byte pulse, qualified by `wr_addr` and `wr_data`.
REQ-011 Port `unknown_cmd` (out, 1): 1-cycle pulse when an unsupported opcode is received.
REQ-012 Port `busy` (out, 1): high whenever the FSM is not in IDLE.

Function
REQ-013 `spi_cs`, `spi_rx_strobe` and `spi_rx_cmd` SHALL each pass through a SYNC_STAGES flop synchronizer; a toggle edge is detected by XOR of the last two synchronized stages.
REQ-014 On a strobe edge, `spi_rx_data` SHALL be captured into a byte register, and a byte event SHALL be processed on the following cycle.
REQ-015 A byte event SHALL be classed as an opcode if a cmd toggle edge was detected in the same cycle as the strobe edge or in the cycle before it; otherwise it is a payload byte.
REQ-016 FSM states: IDLE, ADDR0, ADDR1, ADDR2, DUMMY, READ, PROG, IGNORE.
REQ-017 An opcode event from any state SHALL pulse `cmd_strobe`, load `cmd`, and take the following transitions:
  - 0x03 READ, 0x0B FAST_READ, 0x02 PAGE_PROGRAM -> ADDR0.
  - 0x9F RDID, 0x05 RDSR -> IGNORE.
  - Any other opcode -> IGNORE, and pulse `unknown_cmd`.
REQ-018 Each payload byte in ADDR0, ADDR1 and ADDR2 SHALL load address bits [23:16], [15:8] and [7:0] in turn; bits above ADDR_BITS-1 are discarded.
REQ-019 After ADDR2, the next state SHALL be:
  - READ for 0x03, with `rd_req` pulsed and `rd_addr` set to the address one cycle after the ADDR2 byte event.
  - DUMMY for 0x0B.
  - PROG for 0x02.
REQ-020 A payload byte in DUMMY SHALL move the FSM to READ and pulse `rd_req` with the loaded address on the next cycle.
REQ-021 Each payload byte in READ SHALL increment `rd_addr` by 1 modulo 2^ADDR_BITS and pulse `rd_req`, so `rd_req` runs one byte ahead of the shifter (prefetch).
REQ-022 Each payload byte in PROG SHALL pulse `wr_strobe` with `wr_data` set to the byte and `wr_addr` set to the current address, then increment only address bits [7:0], wrapping within the 256-byte page.
REQ-023 Payload bytes in IDLE or IGNORE SHALL be discarded, with no output pulses.
REQ-024 A synchronized rising edge of `spi_cs` SHALL force IDLE on the next cycle and suppress any pulse for a byte event processed in that same cycle.
REQ-025 At most one of `rd_req` and `wr_strobe` SHALL be high in any cycle.
REQ-026 `cmd`, `rd_addr`, `wr_addr` and `wr_data` SHALL hold their values between pulses.
REQ-027 Correct operation SHALL require the `clk` period to be at most 1/4 of the byte period minus the sync latency, so that no two strobe edges are ever pending at once.

Reset
REQ-028 While `reset` is high at a `clk` edge:
  - The FSM goes to IDLE.
  - All pulse outputs and `busy` go to 0.
  - `cmd`, `rd_addr`, `wr_addr` and `wr_data` go to 0.
  - Synchronizer and edge-detect flops are loaded from the current input levels, so no spurious edge is seen after reset.
REQ-029 Assertion of `reset` mid-transaction SHALL abandon the transaction; payload bytes arriving after reset release SHALL be ignored until the next opcode.

Verification
REQ-030 Bytes 03 12 34 56 then 3 payload bytes SHALL produce:
  - `cmd_strobe` with `cmd`=0x03.
  - `rd_req` at 0x123456, 0x123457, 0x123458 and 0x123459.
  - `busy` high until CS rises.
REQ-031 Bytes 0B 00 00 10, a dummy byte, then 1 byte SHALL produce no `rd_req` before the dummy byte, then `rd_req` at 0x000010 and 0x000011.
REQ-032 Bytes 02 00 01 FE then AA BB CC SHALL produce `wr_strobe` at 0x0001FE/AA, 0x0001FF/BB and 0x000100/CC (page wrap).
REQ-033 Byte 03 FF FF FF then 1 byte SHALL produce `rd_req` at 0xFFFFFF, then at 0x000000.
REQ-034 Byte 0xC7 followed by 2 bytes SHALL produce `unknown_cmd` and `cmd_strobe` once each, with no `rd_req` or `wr_strobe`.
REQ-035 Both of the following SHALL be covered:
  - CS rising after ADDR1 followed by a new 03 00 00 00 sequence yields a single `rd_req` at 0x000000.
  - `reset` asserted in READ, followed by payload bytes, yields no pulses.

Source files
------------

// File: rtl/spi_flash_cmd_parser.sv
// SPI flash command parser: turns synchronized SPI byte events into
// opcode, read-request and program-byte pulses in the clk domain.
module spi_flash_cmd_parser #(
    parameter int ADDR_BITS   = 24,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spi_cs,
    input  logic                 spi_rx_strobe,
    input  logic                 spi_rx_cmd,
    input  logic [7:0]           spi_rx_data,
    output logic                 cmd_strobe,
    output logic [7:0]           cmd,
    output logic                 rd_req,
    output logic [ADDR_BITS-1:0] rd_addr,
    output logic                 wr_strobe,
    output logic [ADDR_BITS-1:0] wr_addr,
    output logic [7:0]           wr_data,
    output logic                 unknown_cmd,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE, ADDR0, ADDR1, ADDR2, DUMMY, READ, PROG, IGNORE
    } state_t;

    localparam logic [ADDR_BITS-1:0] ONE = 1;

    state_t state;

    // bit SYNC_STAGES is one extra delay flop used for edge detection
    logic [SYNC_STAGES:0] cs_sr;
    logic [SYNC_STAGES:0] stb_sr;
    logic [SYNC_STAGES:0] cmd_sr;

    logic cs_rise;
    logic stb_edge;
    logic cmd_edge;
    logic cmd_edge_d;

    logic [7:0]  byte_q;
    logic        byte_evt;
    logic        byte_op;
    logic [23:0] addr_q;
    logic [23:0] addr_full;

    assign cs_rise  = cs_sr[SYNC_STAGES-1] & ~cs_sr[SYNC_STAGES];
    assign stb_edge = stb_sr[SYNC_STAGES-1] ^ stb_sr[SYNC_STAGES];
    assign cmd_edge = cmd_sr[SYNC_STAGES-1] ^ cmd_sr[SYNC_STAGES];

    assign addr_full = {addr_q[23:8], byte_q};
    assign busy      = (state != IDLE);

    // synchronizers; reset preloads current levels so no false edge
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_sr  <= {(SYNC_STAGES+1){spi_cs}};
            stb_sr <= {(SYNC_STAGES+1){spi_rx_strobe}};
            cmd_sr <= {(SYNC_STAGES+1){spi_rx_cmd}};
        end else begin
            cs_sr  <= {cs_sr[SYNC_STAGES-1:0], spi_cs};
            stb_sr <= {stb_sr[SYNC_STAGES-1:0], spi_rx_strobe};
            cmd_sr <= {cmd_sr[SYNC_STAGES-1:0], spi_rx_cmd};
        end
    end

    // capture byte on strobe edge and class it as opcode or payload
    always_ff @(posedge clk) begin
        if (reset) begin
            byte_q     <= 8'h00;
            byte_evt   <= 1'b0;
            byte_op    <= 1'b0;
            cmd_edge_d <= 1'b0;
        end else begin
            byte_evt   <= stb_edge;
            cmd_edge_d <= cmd_edge;
            if (stb_edge) begin
                byte_q  <= spi_rx_data;
                byte_op <= cmd_edge | cmd_edge_d;
            end
        end
    end

    // command FSM with registered pulse and qualifier outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cmd_strobe  <= 1'b0;
            cmd         <= 8'h00;
            rd_req      <= 1'b0;
            rd_addr     <= '0;
            wr_strobe   <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= 8'h00;
            unknown_cmd <= 1'b0;
            addr_q      <= 24'h0;
        end else begin
            cmd_strobe  <= 1'b0;
            rd_req      <= 1'b0;
            wr_strobe   <= 1'b0;
            unknown_cmd <= 1'b0;
            if (cs_rise) begin
                state <= IDLE;
            end else if (byte_evt) begin
                if (byte_op) begin
                    cmd_strobe <= 1'b1;
                    cmd        <= byte_q;
                    unique case (byte_q)
                        8'h03, 8'h0B, 8'h02: state <= ADDR0;
                        8'h9F, 8'h05:        state <= IGNORE;
                        default: begin
                            state       <= IGNORE;
                            unknown_cmd <= 1'b1;
                        end
                    endcase
                end else begin
                    unique case (state)
                        ADDR0: begin
                            addr_q[23:16] <= byte_q;
                            state         <= ADDR1;
                        end
                        ADDR1: begin
                            addr_q[15:8] <= byte_q;
                            state        <= ADDR2;
                        end
                        ADDR2: begin
                            addr_q[7:0] <= byte_q;
                            unique case (cmd)
                                8'h03: begin
                                    state   <= READ;
                                    rd_req  <= 1'b1;
                                    rd_addr <= addr_full[ADDR_BITS-1:0];
                                end
                                8'h0B:   state <= DUMMY;
                                default: state <= PROG;
                            endcase
                        end
                        DUMMY: begin
                            state   <= READ;
                            rd_req  <= 1'b1;
                            rd_addr <= addr_q[ADDR_BITS-1:0];
                        end
                        READ: begin
                            rd_req  <= 1'b1;
                            rd_addr <= rd_addr + ONE;
                        end
                        PROG: begin
                            wr_strobe   <= 1'b1;
                            wr_data     <= byte_q;
                            wr_addr     <= addr_q[ADDR_BITS-1:0];
                            addr_q[7:0] <= addr_q[7:0] + 8'd1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_flash_cmd_parser.sv
// Self-checking bench for spi_flash_cmd_parser: vector table plus
// hand sequences, outputs matched against an expected-event queue.
module tb_spi_flash_cmd_parser;

    localparam logic [1:0] K_CMD = 2'd0;
    localparam logic [1:0] K_UNK = 2'd1;
    localparam logic [1:0] K_RD  = 2'd2;
    localparam logic [1:0] K_WR  = 2'd3;

    typedef struct packed {
        logic [1:0]  k;
        logic [23:0] a;
        logic [7:0]  d;
    } ev_t;

    typedef struct packed {
        logic [0:7][7:0] b;
        int              n;
        ev_t [0:5]       e;
        int              ne;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        spi_cs;
    logic        spi_rx_strobe;
    logic        spi_rx_cmd;
    logic [7:0]  spi_rx_data;
    logic        cmd_strobe;
    logic [7:0]  cmd;
    logic        rd_req;
    logic [23:0] rd_addr;
    logic        wr_strobe;
    logic [23:0] wr_addr;
    logic [7:0]  wr_data;
    logic        unknown_cmd;
    logic        busy;

    int checks = 0;
    int errors = 0;
    ev_t exp_q[$];
    vec_t vt [0:5];

    spi_flash_cmd_parser #(.ADDR_BITS(24), .SYNC_STAGES(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .spi_cs        (spi_cs),
        .spi_rx_strobe (spi_rx_strobe),
        .spi_rx_cmd    (spi_rx_cmd),
        .spi_rx_data   (spi_rx_data),
        .cmd_strobe    (cmd_strobe),
        .cmd           (cmd),
        .rd_req        (rd_req),
        .rd_addr       (rd_addr),
        .wr_strobe     (wr_strobe),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .unknown_cmd   (unknown_cmd),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    function automatic ev_t ev(logic [1:0] k, logic [23:0] a, logic [7:0] d);
        ev_t r;
        r.k = k;
        r.a = a;
        r.d = d;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    task automatic match(ev_t obs);
        ev_t want;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pulse got k=%0d a=%h d=%h want none",
                     obs.k, obs.a, obs.d);
        end else begin
            want = exp_q.pop_front();
            if (obs !== want) begin
                errors++;
                $display("FAIL pulse got k=%0d a=%h d=%h want k=%0d a=%h d=%h",
                         obs.k, obs.a, obs.d, want.k, want.a, want.d);
            end
        end
    endtask

    task automatic monitor();
        if (cmd_strobe)  match(ev(K_CMD, 24'h0, cmd));
        if (unknown_cmd) match(ev(K_UNK, 24'h0, cmd));
        if (rd_req)      match(ev(K_RD, rd_addr, 8'h00));
        if (wr_strobe)   match(ev(K_WR, wr_addr, wr_data));
        if (rd_req || wr_strobe)
            chk("rd_wr_exclusive", {31'd0, rd_req & wr_strobe}, 32'd0);
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
    endtask

    task automatic send_byte(logic [7:0] d, bit first);
        spi_rx_data = d;
        if (first) spi_rx_cmd = ~spi_rx_cmd;
        spi_rx_strobe = ~spi_rx_strobe;
        repeat (16) tick();
    endtask

    task automatic end_seq(string name);
        chk({name, "_busy_before_cs"}, {31'd0, busy}, 32'd1);
        spi_cs = 1'b1;
        repeat (10) tick();
        chk({name, "_busy_after_cs"}, {31'd0, busy}, 32'd0);
        chk({name, "_missing_pulses"}, exp_q.size(), 32'd0);
        exp_q.delete();
        spi_cs = 1'b0;
        repeat (4) tick();
    endtask

    initial begin
        vt[0].b = 64'h03_12_34_56_01_02_03_00; vt[0].n = 7; vt[0].ne = 5;
        vt[0].e[0] = ev(K_CMD, 24'h0, 8'h03);
        vt[0].e[1] = ev(K_RD, 24'h123456, 8'h00);
        vt[0].e[2] = ev(K_RD, 24'h123457, 8'h00);
        vt[0].e[3] = ev(K_RD, 24'h123458, 8'h00);
        vt[0].e[4] = ev(K_RD, 24'h123459, 8'h00);
        vt[1].b = 64'h0B_00_00_10_A5_5A_00_00; vt[1].n = 6; vt[1].ne = 3;
        vt[1].e[0] = ev(K_CMD, 24'h0, 8'h0B);
        vt[1].e[1] = ev(K_RD, 24'h000010, 8'h00);
        vt[1].e[2] = ev(K_RD, 24'h000011, 8'h00);
        vt[2].b = 64'h02_00_01_FE_AA_BB_CC_00; vt[2].n = 7; vt[2].ne = 4;
        vt[2].e[0] = ev(K_CMD, 24'h0, 8'h02);
        vt[2].e[1] = ev(K_WR, 24'h0001FE, 8'hAA);
        vt[2].e[2] = ev(K_WR, 24'h0001FF, 8'hBB);
        vt[2].e[3] = ev(K_WR, 24'h000100, 8'hCC);
        vt[3].b = 64'h03_FF_FF_FF_77_00_00_00; vt[3].n = 5; vt[3].ne = 3;
        vt[3].e[0] = ev(K_CMD, 24'h0, 8'h03);
        vt[3].e[1] = ev(K_RD, 24'hFFFFFF, 8'h00);
        vt[3].e[2] = ev(K_RD, 24'h000000, 8'h00);
        vt[4].b = 64'hC7_11_22_00_00_00_00_00; vt[4].n = 3; vt[4].ne = 2;
        vt[4].e[0] = ev(K_CMD, 24'h0, 8'hC7);
        vt[4].e[1] = ev(K_UNK, 24'h0, 8'hC7);
        vt[5].b = 64'h9F_00_00_00_00_00_00_00; vt[5].n = 4; vt[5].ne = 1;
        vt[5].e[0] = ev(K_CMD, 24'h0, 8'h9F);

        reset = 1'b1;
        spi_cs = 1'b1;
        spi_rx_strobe = 1'b0;
        spi_rx_cmd = 1'b0;
        spi_rx_data = 8'h00;
        repeat (3) tick();
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_cmd", {24'd0, cmd}, 32'd0);
        chk("reset_rd_addr", {8'd0, rd_addr}, 32'd0);
        chk("reset_wr_addr", {8'd0, wr_addr}, 32'd0);
        chk("reset_wr_data", {24'd0, wr_data}, 32'd0);
        reset = 1'b0;
        repeat (3) tick();
        spi_cs = 1'b0;
        repeat (4) tick();

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < vt[v].ne; i++) exp_q.push_back(vt[v].e[i]);
            for (int i = 0; i < vt[v].n; i++) send_byte(vt[v].b[i], i == 0);
            end_seq($sformatf("vec%0d", v));
        end

        // CS rises after ADDR1, then a fresh read at address 0
        exp_q.push_back(ev(K_CMD, 24'h0, 8'h03));
        send_byte(8'h03, 1'b1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        spi_cs = 1'b1;
        repeat (10) tick();
        chk("cs_abort_idle", {31'd0, busy}, 32'd0);
        spi_cs = 1'b0;
        repeat (4) tick();
        exp_q.push_back(ev(K_CMD, 24'h0, 8'h03));
        exp_q.push_back(ev(K_RD, 24'h000000, 8'h00));
        send_byte(8'h03, 1'b1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        end_seq("cs_abort");

        // reset in READ, later payload bytes must be ignored
        exp_q.push_back(ev(K_CMD, 24'h0, 8'h03));
        exp_q.push_back(ev(K_RD, 24'h000020, 8'h00));
        send_byte(8'h03, 1'b1);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h20, 1'b0);
        chk("pre_reset_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        repeat (2) tick();
        chk("mid_reset_busy", {31'd0, busy}, 32'd0);
        chk("mid_reset_rd_addr", {8'd0, rd_addr}, 32'd0);
        chk("mid_reset_cmd", {24'd0, cmd}, 32'd0);
        send_byte(8'h44, 1'b0);
        send_byte(8'h55, 1'b0);
        chk("post_reset_busy", {31'd0, busy}, 32'd0);
        chk("post_reset_pending", exp_q.size(), 32'd0);
        spi_cs = 1'b1;
        repeat (10) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
